// File: rtl/gate_alu_scheduler.sv
// Round-robin scheduler sharing one registered 4-bit logic-gate datapath among NREQ requesters.
// One op in flight: IDLE (grant + latch) -> EXEC (compute) -> DONE (hold until res_ready).
module gate_alu_scheduler #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [3*NREQ-1:0] req_op,
    input  logic [W*NREQ-1:0] req_a,
    input  logic [W*NREQ-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [W-1:0]      res_data,
    output logic [2:0]        res_id,
    output logic              res_err,
    output logic              busy,
    output logic [7:0]        ops_done
);

    localparam int unsigned IdW = 3;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [IdW-1:0] rr_ptr_q, rr_ptr_d;
    logic [2:0]     op_q, op_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d;
    logic [IdW-1:0] id_q, id_d;
    logic           res_valid_q, res_valid_d;
    logic [W-1:0]   res_data_q, res_data_d;
    logic [IdW-1:0] res_id_q, res_id_d;
    logic           res_err_q, res_err_d;
    logic [7:0]     ops_done_q, ops_done_d;

    logic [2*NREQ-1:0] valid_rot;
    logic              grant_found;
    logic [IdW-1:0]    grant_idx;
    logic [IdW:0]      grant_sum;
    logic [2:0]        op_sel;
    logic [W-1:0]      a_sel, b_sel;
    logic [W-1:0]      alu_res;
    logic              alu_err;

    // Rotate so that bit 0 is the rr_ptr requester; first set bit is the winner's offset.
    always_comb begin
        valid_rot   = {req_valid, req_valid} >> rr_ptr_q;
        grant_found = 1'b0;
        grant_sum   = '0;
        grant_idx   = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!grant_found && valid_rot[i]) begin
                grant_found = 1'b1;
                grant_sum   = {1'b0, rr_ptr_q} + (IdW+1)'(i);
            end
        end
        if (grant_sum >= (IdW+1)'(NREQ)) begin
            grant_idx = IdW'(grant_sum - (IdW+1)'(NREQ));
        end else begin
            grant_idx = grant_sum[IdW-1:0];
        end
    end

    always_comb begin
        op_sel    = '0;
        a_sel     = '0;
        b_sel     = '0;
        req_ready = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (grant_idx == IdW'(i)) begin
                op_sel = req_op[3*i +: 3];
                a_sel  = req_a[W*i +: W];
                b_sel  = req_b[W*i +: W];
                req_ready[i] = (state_q == IDLE) && grant_found;
            end
        end
    end

    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (op_q)
            3'd0:    alu_res = ~a_q;
            3'd1:    alu_res = a_q & b_q;
            3'd2:    alu_res = a_q | b_q;
            3'd3:    alu_res = a_q ^ b_q;
            3'd4:    alu_res = ~(a_q & b_q);
            3'd5:    alu_res = a_q;
            default: alu_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        res_err_d   = res_err_q;
        ops_done_d  = ops_done_q;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    op_d     = op_sel;
                    a_d      = a_sel;
                    b_d      = b_sel;
                    id_d     = grant_idx;
                    rr_ptr_d = (grant_idx == IdW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                res_data_d  = alu_res;
                res_err_d   = alu_err;
                res_id_d    = id_q;
                res_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    ops_done_d  = ops_done_q + 8'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
            res_err_q   <= 1'b0;
            ops_done_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            res_err_q   <= res_err_d;
            ops_done_q  <= ops_done_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign res_err   = res_err_q;
    assign busy      = (state_q != IDLE);
    assign ops_done  = ops_done_q;

endmodule

// File: tb/tb_gate_alu_scheduler.sv
// Directed bench for gate_alu_scheduler: arbitration order, latency, backpressure,
// reserved opcodes, mid-op reset and ops_done wrap, with hand-computed expectations.
module tb_gate_alu_scheduler;

    localparam int NREQ = 4;
    localparam int W    = 4;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [3*NREQ-1:0] req_op;
    logic [W*NREQ-1:0] req_a;
    logic [W*NREQ-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              res_valid;
    logic              res_ready;
    logic [W-1:0]      res_data;
    logic [2:0]        res_id;
    logic              res_err;
    logic              busy;
    logic [7:0]        ops_done;

    int checks = 0;
    int passed = 0;

    gate_alu_scheduler #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_err   (res_err),
        .busy      (busy),
        .ops_done  (ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance past the next rising edge; outputs settle well away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [2:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b);
        req_op[3*i +: 3] = op;
        req_a[W*i +: W]  = a;
        req_b[W*i +: W]  = b;
    endtask

    initial begin
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b0;
        rst_n     = 1'b1;
        #2 rst_n  = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_res_valid", 32'(res_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ops_done", 32'(ops_done), 32'h0);
        chk("rst_res_data", 32'(res_data), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;

        // Idle with nothing requested.
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("idle_req_ready", 32'(req_ready), 32'h0);
            chk("idle_res_valid", 32'(res_valid), 32'h0);
            chk("idle_busy", 32'(busy), 32'h0);
        end
        chk("idle_ops_done", 32'(ops_done), 32'h0);

        // Single requester 2: 0xC & 0xA = 0x8.
        res_ready = 1'b1;
        set_req(2, 3'd1, 4'hC, 4'hA);
        req_valid = 4'b0100;
        #1;
        chk("r2_grant", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        chk("r2_exec_ready", 32'(req_ready), 32'h0);
        chk("r2_exec_busy", 32'(busy), 32'h1);
        chk("r2_exec_valid", 32'(res_valid), 32'h0);
        tick();
        chk("r2_valid", 32'(res_valid), 32'h1);
        chk("r2_data", 32'(res_data), 32'h8);
        chk("r2_id", 32'(res_id), 32'h2);
        chk("r2_err", 32'(res_err), 32'h0);
        tick();
        chk("r2_done_valid", 32'(res_valid), 32'h0);
        chk("r2_ops_done", 32'(ops_done), 32'h1);
        chk("r2_idle_busy", 32'(busy), 32'h0);

        // Fresh reset so rr_ptr is 0, then all four requesters NOT their index.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 3'd0, 4'(i), 4'h0);
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            int g;
            g = k % NREQ;
            #1;
            chk("rr_grant", 32'(req_ready), 32'(1 << g));
            tick();
            tick();
            chk("rr_id", 32'(res_id), 32'(g));
            chk("rr_data", 32'(res_data), 32'(4'hF - 4'(g)));
            tick();
        end
        req_valid = '0;
        chk("rr_ops_done", 32'(ops_done), 32'h5);

        // Backpressure: rr_ptr=1, requester 1 XOR 0x5^0xF = 0xA.
        res_ready = 1'b0;
        set_req(1, 3'd3, 4'h5, 4'hF);
        req_valid = 4'b0010;
        #1;
        chk("bp_grant", 32'(req_ready), 32'h2);
        tick();
        set_req(0, 3'd5, 4'h9, 4'h0);
        req_valid = 4'b0001;
        tick();
        for (int c = 0; c < 4; c++) begin
            chk("bp_valid", 32'(res_valid), 32'h1);
            chk("bp_data", 32'(res_data), 32'hA);
            chk("bp_id", 32'(res_id), 32'h1);
            chk("bp_ready_low", 32'(req_ready), 32'h0);
            tick();
        end
        res_ready = 1'b1;
        tick();
        chk("bp_ops_done", 32'(ops_done), 32'h6);
        chk("bp_next_grant", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        tick();
        chk("bp_r0_data", 32'(res_data), 32'h9);
        chk("bp_r0_id", 32'(res_id), 32'h0);
        tick();

        // Reserved opcode from requester 3, then NAND 0xF,0x3 = 0xC.
        set_req(3, 3'd7, 4'h5, 4'h5);
        req_valid = 4'b1000;
        #1;
        chk("rsv_grant", 32'(req_ready), 32'h8);
        tick();
        set_req(3, 3'd4, 4'hF, 4'h3);
        tick();
        chk("rsv_data", 32'(res_data), 32'h0);
        chk("rsv_err", 32'(res_err), 32'h1);
        chk("rsv_id", 32'(res_id), 32'h3);
        tick();
        chk("nand_grant", 32'(req_ready), 32'h8);
        tick();
        req_valid = '0;
        tick();
        chk("nand_data", 32'(res_data), 32'hC);
        chk("nand_err", 32'(res_err), 32'h0);
        tick();
        chk("nand_ops_done", 32'(ops_done), 32'h9);

        // Reset while in EXEC discards the op and rewinds rr_ptr.
        set_req(2, 3'd5, 4'h7, 4'h0);
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        chk("mr_busy_exec", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mr_busy", 32'(busy), 32'h0);
        chk("mr_ops_done", 32'(ops_done), 32'h0);
        chk("mr_res_data", 32'(res_data), 32'h0);
        chk("mr_res_valid", 32'(res_valid), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("mr_no_result", 32'(res_valid), 32'h0);
        set_req(0, 3'd5, 4'h6, 4'h0);
        req_valid = 4'b0101;
        #1;
        chk("mr_r0_wins", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        tick();
        chk("mr_r0_data", 32'(res_data), 32'h6);
        tick();
        chk("mr_ops_done1", 32'(ops_done), 32'h1);

        // 255 more ops from requester 0 wrap ops_done 255 -> 0.
        req_valid = 4'b0001;
        for (int n = 0; n < 254; n++) begin
            tick();
            tick();
            tick();
        end
        chk("wrap_255", 32'(ops_done), 32'hFF);
        tick();
        tick();
        tick();
        req_valid = '0;
        chk("wrap_0", 32'(ops_done), 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
